// File: rtl/board_ctrl_if.sv
// Signal bundle between board_ctrl and the tv_b_gone core: derived clock/reset
// outputs plus raw and debounced button lines.
interface board_ctrl_if #(
  parameter int N_BTN = 2
);
  logic             clk_en_out;
  logic             clk_div_out;
  logic             rst_out;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level_out;
  logic [N_BTN-1:0] btn_press_out;
  logic [N_BTN-1:0] btn_release_out;

  modport master (
    output clk_en_out,
    output clk_div_out,
    output rst_out,
    output btn_level_out,
    output btn_press_out,
    output btn_release_out,
    input  btn_in
  );

  modport slave (
    input  clk_en_out,
    input  clk_div_out,
    input  rst_out,
    input  btn_level_out,
    input  btn_press_out,
    input  btn_release_out,
    output btn_in
  );
endinterface

// File: rtl/board_ctrl.sv
// Board support for the iCE40 TV-B-Gone tops: integer clock divider, reset
// stretcher and N_BTN synchronised/debounced buttons with press/release pulses.
module board_ctrl #(
  parameter int CLK_DIV         = 3,
  parameter int RST_CYCLES      = 65536,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic          clk_24M,
  input  logic          resetn,
  board_ctrl_if.master  io
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RC_W  = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES);
  localparam logic [DB_W-1:0]  DEB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] BTN_IDLE = {N_BTN{BTN_ACTIVE_LOW != 0}};

  // divider
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             clk_en_q,  clk_en_d;
  logic             clk_div_q, clk_div_d;

  // reset stretcher
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             rst_out_q, rst_out_d;

  // buttons
  logic [N_BTN-1:0] sync1_q,   sync1_d;
  logic [N_BTN-1:0] sync2_q,   sync2_d;
  logic [N_BTN-1:0] level_q,   level_d;
  logic [N_BTN-1:0] press_q,   press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [DB_W-1:0]  deb_cnt_q [N_BTN];
  logic [DB_W-1:0]  deb_cnt_d [N_BTN];
  logic [N_BTN-1:0] btn_sync;

  always_comb begin
    div_cnt_d = div_cnt_q - DIV_W'(1);
    clk_en_d  = 1'b0;
    clk_div_d = clk_div_q;
    if (div_cnt_q == '0) begin
      div_cnt_d = DIV_LAST;
      clk_en_d  = 1'b1;
      clk_div_d = ~clk_div_q;
    end
  end

  always_comb begin
    rst_out_d = rst_out_q;
    rst_cnt_d = rst_cnt_q;
    if (rst_out_q) begin
      if (rst_cnt_q == RST_LAST) begin
        rst_out_d = 1'b0;
      end else begin
        rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
    end
  end

  assign btn_sync = sync2_q ^ BTN_IDLE;

  // The first sync stage keeps sampling through the stretch, so a button held
  // across reset release is seen with the normal debounce latency.
  always_comb begin
    sync1_d   = io.btn_in;
    sync2_d   = rst_out_q ? BTN_IDLE : sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i] = '0;
      if (rst_out_q) begin
        level_d[i] = 1'b0;
      end else if (btn_sync[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i]   = btn_sync[i];
          press_d[i]   = btn_sync[i];
          release_d[i] = ~btn_sync[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_24M) begin
    if (!resetn) begin
      div_cnt_q <= DIV_LAST;
      clk_en_q  <= 1'b0;
      clk_div_q <= 1'b0;
      rst_cnt_q <= '0;
      rst_out_q <= 1'b1;
      sync1_q   <= BTN_IDLE;
      sync2_q   <= BTN_IDLE;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      deb_cnt_q <= '{default: '0};
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_en_q  <= clk_en_d;
      clk_div_q <= clk_div_d;
      rst_cnt_q <= rst_cnt_d;
      rst_out_q <= rst_out_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign io.clk_en_out      = clk_en_q;
  assign io.clk_div_out     = clk_div_q;
  assign io.rst_out         = rst_out_q;
  assign io.btn_level_out   = level_q;
  assign io.btn_press_out   = press_q;
  assign io.btn_release_out = release_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: divider, reset stretcher and debounce timing
// on the test build, plus a CLK_DIV=1 / RST_CYCLES=0 build sharing clk/resetn.
module tb_board_ctrl;

  logic clk_24M = 1'b0;
  logic resetn  = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk_24M = ~clk_24M;

  board_ctrl_if #(.N_BTN(2)) bus0 ();
  board_ctrl_if #(.N_BTN(2)) bus1 ();

  board_ctrl #(
    .CLK_DIV(3), .RST_CYCLES(16), .N_BTN(2), .DEBOUNCE_CYCLES(8), .BTN_ACTIVE_LOW(1)
  ) u_dut (
    .clk_24M (clk_24M),
    .resetn  (resetn),
    .io      (bus0)
  );

  board_ctrl #(
    .CLK_DIV(1), .RST_CYCLES(0), .N_BTN(2), .DEBOUNCE_CYCLES(8), .BTN_ACTIVE_LOW(1)
  ) u_dut1 (
    .clk_24M (clk_24M),
    .resetn  (resetn),
    .io      (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] btn_obs();
    return {bus0.btn_level_out, bus0.btn_press_out, bus0.btn_release_out};
  endfunction

  task automatic tick();
    @(posedge clk_24M);
    #1;
  endtask

  // n cycles with no pulses and a fixed level
  task automatic quiet(input int unsigned n, input logic [1:0] lvl, input string tag);
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      check(tag, btn_obs(), {lvl, 4'b0000});
    end
  endtask

  task automatic step_chk(input string tag, input logic [5:0] exp);
    tick();
    check(tag, btn_obs(), exp);
  endtask

  initial begin
    bus0.btn_in = 2'b11;
    bus1.btn_in = 2'b11;
    resetn      = 1'b0;

    // 1: reset state, divider and stretch
    for (int unsigned k = 0; k < 5; k++) tick();
    check("rst_clk_en",  bus0.clk_en_out, 1'b0);
    check("rst_clk_div", bus0.clk_div_out, 1'b0);
    check("rst_rst_out", bus0.rst_out, 1'b1);
    check("rst_btn",     btn_obs(), 6'b0);
    check("rst1_rst_out", bus1.rst_out, 1'b1);
    check("rst1_clk_en",  bus1.clk_en_out, 1'b0);
    resetn = 1'b1;
    for (int unsigned k = 1; k <= 20; k++) begin
      tick();
      check("stretch_rst_out", bus0.rst_out, (k <= 16) ? 1'b1 : 1'b0);
      check("div_clk_en",  bus0.clk_en_out, (k % 3 == 0) ? 1'b1 : 1'b0);
      check("div_clk_div", bus0.clk_div_out, ((k / 3) % 2 == 1) ? 1'b1 : 1'b0);
      check("div1_clk_en",  bus1.clk_en_out, 1'b1);
      check("div1_clk_div", bus1.clk_div_out, (k % 2 == 1) ? 1'b1 : 1'b0);
      check("div1_rst_out", bus1.rst_out, 1'b0);
    end

    // 2: clean press on ch0
    bus0.btn_in = 2'b10;
    quiet(9, 2'b00, "press_wait");
    step_chk("press_pulse", 6'b01_01_00);
    step_chk("press_after", 6'b01_00_00);

    // clean release
    bus0.btn_in = 2'b11;
    quiet(9, 2'b01, "rel_wait");
    step_chk("rel_pulse", 6'b00_00_01);
    step_chk("rel_after", 6'b00_00_00);

    // 3: 5-cycle glitch discarded
    bus0.btn_in = 2'b10;
    quiet(5, 2'b00, "glitch5_low");
    bus0.btn_in = 2'b11;
    quiet(10, 2'b00, "glitch5_after");

    // 10-cycle glitch accepted as press then release
    bus0.btn_in = 2'b10;
    quiet(9, 2'b00, "glitch10_wait");
    step_chk("glitch10_press", 6'b01_01_00);
    bus0.btn_in = 2'b11;
    quiet(9, 2'b01, "glitch10_hold");
    step_chk("glitch10_rel", 6'b00_00_01);
    step_chk("glitch10_idle", 6'b00_00_00);

    // 4: simultaneous press, then ch1 release while ch0 bounces
    bus0.btn_in = 2'b00;
    quiet(9, 2'b00, "both_wait");
    step_chk("both_press", 6'b11_11_00);
    step_chk("both_after", 6'b11_00_00);
    for (int unsigned t = 0; t < 12; t++) begin
      bus0.btn_in = {1'b1, ((t / 3) % 2 == 0) ? 1'b1 : 1'b0};
      tick();
      if (t < 9)       check("bounce_pre",  btn_obs(), 6'b11_00_00);
      else if (t == 9) check("bounce_rel1", btn_obs(), 6'b01_00_10);
      else             check("bounce_post", btn_obs(), 6'b01_00_00);
    end
    bus0.btn_in = 2'b10;
    quiet(10, 2'b01, "bounce_settle");

    // 5/6: reset with button held, mid-stretch restart
    resetn = 1'b0;
    tick();
    check("rst2_rst_out", bus0.rst_out, 1'b1);
    check("rst2_btn", btn_obs(), 6'b0);
    check("rst2_1_rst_out", bus1.rst_out, 1'b1);
    check("rst2_1_clk_en",  bus1.clk_en_out, 1'b0);
    resetn = 1'b1;
    for (int unsigned k = 1; k <= 7; k++) begin
      tick();
      check("mid_rst_out", bus0.rst_out, 1'b1);
      check("mid_btn", btn_obs(), 6'b0);
      if (k == 1) check("mid1_rst_out", bus1.rst_out, 1'b0);
    end
    resetn = 1'b0;
    tick();
    check("pulse_rst_out", bus0.rst_out, 1'b1);
    check("pulse1_rst_out", bus1.rst_out, 1'b1);
    resetn = 1'b1;
    for (int unsigned k = 1; k <= 25; k++) begin
      tick();
      check("restart_rst_out", bus0.rst_out, (k <= 16) ? 1'b1 : 1'b0);
      check("restart_btn", btn_obs(), 6'b0);
      if (k == 1) begin
        check("restart1_rst_out", bus1.rst_out, 1'b0);
        check("restart1_clk_en",  bus1.clk_en_out, 1'b1);
      end
    end
    step_chk("held_press", 6'b01_01_00);
    step_chk("held_after", 6'b01_00_00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_ctrl.md
Name: board_ctrl

Overview:
- Parametrised board-support block for the iCE40 TV-B-Gone tops. Generalises the fixed divide-by-3 clock, the fixed reset pulse and the single raw button into one reusable block.
- Provides:
  - an integer clock divider, as a one-cycle enable strobe plus a square wave;
  - a configurable-length reset stretcher;
  - N_BTN synchronised, debounced, polarity-normalised buttons with press/release pulses.
- Sits between the SB_HFOSC output (clk_24M) and the tv_b_gone core.

Parameters:
- CLK_DIV, 3: divide ratio, integer >= 1.
- RST_CYCLES, 65536: clk_24M cycles that rst_out stays high after resetn goes high, >= 0.
- N_BTN, 2: number of button channels, >= 1.
- DEBOUNCE_CYCLES, 240000: stable cycles required before a button change is accepted (10 ms at 24 MHz), >= 1.
- BTN_ACTIVE_LOW, 1: 1 means raw button pressed = 0; 0 means pressed = 1.

Ports:
- clk_24M  in  1  system clock, 24 MHz.
- resetn  in  1  reset, synchronous, active-low.
- clk_en_out  out  1  one-cycle strobe every CLK_DIV clocks.
- clk_div_out  out  1  square wave, period 2*CLK_DIV clocks.
- rst_out  out  1  stretched active-high reset for downstream logic.
- btn_in  in  N_BTN  raw asynchronous button pins.
- btn_level_out  out  N_BTN  debounced state, 1 = pressed.
- btn_press_out  out  N_BTN  one-cycle pulse on accepted press.
- btn_release_out  out  N_BTN  one-cycle pulse on accepted release.

Behaviour:
- All state is registered on posedge clk_24M. Reset is synchronous, active-low (resetn), clock clk_24M.
- Reset values while resetn=0:
  - clk_en_out=0, clk_div_out=0, rst_out=1;
  - btn_level_out=0, btn_press_out=0, btn_release_out=0;
  - sync flops hold the inactive raw level; all counters are 0, except div_cnt, which is CLK_DIV-1.
- Divider:
  - div_cnt, width clog2(CLK_DIV) (min 1), decrements each cycle.
  - When div_cnt==0 it reloads CLK_DIV-1, the next-cycle clk_en_out=1, and clk_div_out toggles.
  - First strobe appears CLK_DIV cycles after resetn rises.
  - CLK_DIV=1: clk_en_out stays 1 continuously after the first cycle, and clk_div_out toggles every cycle.
  - The divider runs independently of rst_out.
- Reset stretcher:
  - rst_cnt counts up while rst_out=1 and resetn=1.
  - rst_out is held high for exactly RST_CYCLES cycles counted from the first edge sampling resetn=1, then drops and stays low.
  - RST_CYCLES=0: rst_out is resetn inverted and registered (one cycle latency).
  - resetn low at any time, including mid-stretch, restarts the full count.
- Button channel i (fully independent per channel):
  - 2-flop synchroniser on btn_in[i], then polarity normalised to pressed=1 (the sync output).
  - When sync != btn_level_out[i], deb_cnt increments; when sync == level, deb_cnt clears to 0.
  - When deb_cnt==DEBOUNCE_CYCLES-1 with sync still != level:
    - level is updated and deb_cnt cleared;
    - btn_press_out[i] (0->1) or btn_release_out[i] (1->0) pulses for exactly that one cycle.
  - Latency: a clean raw transition sampled at edge N updates level and the pulse at edge N+DEBOUNCE_CYCLES+1.
  - Any excursion shorter than DEBOUNCE_CYCLES cycles at the sync output is discarded.
  - Press and release are never asserted together on one channel.
  - While rst_out=1 the button logic is held in its reset state: no pulses, level 0, counters 0. A button held down through reset release is reported as a press DEBOUNCE_CYCLES+1 cycles later.
- deb_cnt width is clog2(DEBOUNCE_CYCLES)+1; it must never wrap.

Test Plan (CLK_DIV=3, RST_CYCLES=16, N_BTN=2, DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=1):
1. resetn low 5 cycles, then high -> rst_out=1 for exactly 16 cycles after the first high sample, then 0. clk_en_out pulses every 3rd cycle, first at cycle 3. clk_div_out period is 6 cycles.
2. After rst_out falls, btn_in[0] 1->0 at edge N held low -> btn_level_out[0]=1 and btn_press_out[0] single pulse at edge N+9. Channel 1 stays 0.
3. btn_in[0] low glitch of 5 cycles -> no level change, no pulses. Glitch of 10 cycles -> press pulse, then release pulse after it returns high, each 9 cycles after the edge.
4. Both channels pressed on the same edge -> both press pulses in the same cycle. Releasing ch1 while ch0 is still bouncing (toggle every 3 cycles) -> only ch1 release reported.
5. resetn pulsed low for 1 cycle at cycle 8 of the stretch -> stretch restarts, rst_out high 16 more cycles. Reset asserted with a button held -> level returns to 0, press re-reported 9 cycles after rst_out falls.
6. CLK_DIV=1, RST_CYCLES=0 build -> clk_en_out constantly 1 after reset, clk_div_out toggles every cycle, rst_out = resetn inverted delayed by 1 cycle.
